// File: rtl/dpwm_seq_ctrl.sv
// dpwm_seq_ctrl: start-up / run / shutdown sequencer for the open-loop DPWM stage.
// Optional feature: define DPWM_SEQ_AUTORETRY_EN for timed automatic restart out of FAULT.
module dpwm_seq_ctrl #(
    parameter int unsigned RAMP_DIV      = 4,
    parameter int unsigned PRECHARGE_CYC = 1000,
    parameter logic [7:0]  DUTY_MAX      = 8'd225,
    parameter int unsigned RETRY_CYC     = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       stop,
    input  logic       fault,
    input  logic       clear_fault,
    input  logic       period_end,
    input  logic [7:0] duty_tgt,
    input  logic [3:0] freq_req,
    input  logic [2:0] dt1_req,
    input  logic [2:0] dt2_req,
    output logic       EN,
    output logic [7:0] duty_8b,
    output logic [3:0] freq_4b,
    output logic [2:0] dt1_3b,
    output logic [2:0] dt2_3b,
    output logic [2:0] state,
    output logic       fault_latched
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRECHG = 3'd1,
        S_RAMP   = 3'd2,
        S_RUN    = 3'd3,
        S_SHDN   = 3'd4,
        S_FAULT  = 3'd5
    } st_t;

    // One counter serves both the precharge wait and the retry hold-off.
    localparam int unsigned CNT_MAX = (RETRY_CYC > PRECHARGE_CYC) ? RETRY_CYC : PRECHARGE_CYC;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRECHARGE_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
`ifdef DPWM_SEQ_AUTORETRY_EN
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYC - 1);
`endif

    st_t              st_q, st_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             en_n;
    logic [7:0]       duty_n, tgt, duty_inc;
    logic [3:0]       freq_n, freq_c;
    logic [2:0]       dt1_n, dt2_n, dt1_c, dt2_c;
    logic             step;

    assign freq_c   = (freq_req > 4'b1010) ? 4'b1010 : freq_req;
    assign dt1_c    = (dt1_req == 3'd0 || dt1_req > 3'b101) ? 3'b101 : dt1_req;
    assign dt2_c    = (dt2_req == 3'd0 || dt2_req > 3'b101) ? 3'b101 : dt2_req;
    assign tgt      = (duty_tgt > DUTY_MAX) ? DUTY_MAX : duty_tgt;
    assign duty_inc = duty_8b + 8'd1;
    assign step     = period_end && (div_q == DIV_LAST);
    assign state    = st_q;

    always_comb begin
        st_n   = st_q;
        en_n   = EN;
        duty_n = duty_8b;
        freq_n = freq_4b;
        dt1_n  = dt1_3b;
        dt2_n  = dt2_3b;
        cnt_n  = cnt_q;
        div_n  = div_q;
        if (fault && st_q != S_FAULT) begin
            st_n   = S_FAULT;
            en_n   = 1'b0;
            duty_n = 8'd0;
        end else if (stop && (st_q == S_PRECHG || st_q == S_RAMP || st_q == S_RUN)) begin
            st_n = S_SHDN;
        end else begin
            case (st_q)
                S_IDLE: begin
                    en_n   = 1'b0;
                    duty_n = 8'd0;
                    if (start && !stop) begin
                        st_n   = S_PRECHG;
                        freq_n = freq_c;
                        dt1_n  = dt1_c;
                        dt2_n  = dt2_c;
                    end
                end
                S_PRECHG: begin
                    en_n = 1'b0;
                    if (cnt_q != PRE_LAST) begin
                        cnt_n = cnt_q + 1'b1;
                    end else if (period_end) begin
                        st_n   = S_RAMP;
                        en_n   = 1'b1;
                        duty_n = 8'd0;
                    end
                end
                S_RAMP: begin
                    en_n = 1'b1;
                    if (period_end) div_n = step ? '0 : div_q + 1'b1;
                    if (duty_8b > tgt) begin
                        if (period_end) begin
                            duty_n = tgt;
                            st_n   = S_RUN;
                        end
                    end else if (duty_8b == tgt) begin
                        st_n = S_RUN;
                    end else if (step) begin
                        duty_n = duty_inc;
                        if (duty_inc == tgt) st_n = S_RUN;
                    end
                end
                S_RUN: begin
                    en_n = 1'b1;
                    if (period_end) begin
                        freq_n = freq_c;
                        dt1_n  = dt1_c;
                        dt2_n  = dt2_c;
                        // A new switching frequency restarts the soft-start from zero duty.
                        if (freq_c != freq_4b) begin
                            duty_n = 8'd0;
                            st_n   = S_RAMP;
                        end else begin
                            div_n = step ? '0 : div_q + 1'b1;
                            if (step && duty_8b > tgt)      duty_n = duty_8b - 8'd1;
                            else if (step && duty_8b < tgt) duty_n = duty_inc;
                        end
                    end
                end
                S_SHDN: begin
                    if (duty_8b == 8'd0) begin
                        st_n = S_IDLE;
                        en_n = 1'b0;
                    end else if (period_end) begin
                        duty_n = duty_8b - 8'd1;
                    end
                end
                S_FAULT: begin
                    en_n   = 1'b0;
                    duty_n = 8'd0;
                    if (clear_fault && !fault) begin
                        st_n = S_IDLE;
                    end
`ifdef DPWM_SEQ_AUTORETRY_EN
                    else if (fault) begin
                        cnt_n = '0;
                    end else if (cnt_q == RETRY_LAST) begin
                        if (start && !stop) begin
                            st_n   = S_PRECHG;
                            freq_n = freq_c;
                            dt1_n  = dt1_c;
                            dt2_n  = dt2_c;
                        end else begin
                            st_n = S_IDLE;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
`endif
                end
                default: st_n = S_IDLE;
            endcase
        end
        if (st_n != st_q) begin
            cnt_n = '0;
            div_n = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q          <= S_IDLE;
            EN            <= 1'b0;
            duty_8b       <= 8'd0;
            freq_4b       <= 4'b0110;
            dt1_3b        <= 3'b101;
            dt2_3b        <= 3'b101;
            cnt_q         <= '0;
            div_q         <= '0;
            fault_latched <= 1'b0;
        end else begin
            st_q          <= st_n;
            EN            <= en_n;
            duty_8b       <= duty_n;
            freq_4b       <= freq_n;
            dt1_3b        <= dt1_n;
            dt2_3b        <= dt2_n;
            cnt_q         <= cnt_n;
            div_q         <= div_n;
            fault_latched <= (st_n == S_FAULT);
        end
    end
endmodule

// File: tb/tb_dpwm_seq_ctrl.sv
// Directed bench for dpwm_seq_ctrl: a vector table for state/clamp handling plus
// hand-written sequences for precharge, ramp, slew, shutdown, fault and divider timing.
module tb_dpwm_seq_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0, stop = 1'b0, fault = 1'b0, clear_fault = 1'b0, pe = 1'b0;
    logic [7:0] duty_tgt = 8'd0;
    logic [3:0] freq_req = 4'd0;
    logic [2:0] dt1_req = 3'd0, dt2_req = 3'd0;

    logic       en_m, fl_m, en_d, fl_d;
    logic [7:0] duty_m, duty_d;
    logic [3:0] freq_m, freq_d;
    logic [2:0] dt1_m, dt2_m, st_m, dt1_d, dt2_d, st_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpwm_seq_ctrl #(.RAMP_DIV(1), .PRECHARGE_CYC(10), .DUTY_MAX(8'd225), .RETRY_CYC(20)) u_main (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .fault(fault),
        .clear_fault(clear_fault), .period_end(pe), .duty_tgt(duty_tgt), .freq_req(freq_req),
        .dt1_req(dt1_req), .dt2_req(dt2_req), .EN(en_m), .duty_8b(duty_m), .freq_4b(freq_m),
        .dt1_3b(dt1_m), .dt2_3b(dt2_m), .state(st_m), .fault_latched(fl_m));

    dpwm_seq_ctrl #(.RAMP_DIV(3), .PRECHARGE_CYC(2), .DUTY_MAX(8'd20), .RETRY_CYC(20)) u_div (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .fault(fault),
        .clear_fault(clear_fault), .period_end(pe), .duty_tgt(duty_tgt), .freq_req(freq_req),
        .dt1_req(dt1_req), .dt2_req(dt2_req), .EN(en_d), .duty_8b(duty_d), .freq_4b(freq_d),
        .dt1_3b(dt1_d), .dt2_3b(dt2_d), .state(st_d), .fault_latched(fl_d));

    typedef struct packed {
        logic       start, stop, fault, clr, pe;
        logic [3:0] freq;
        logic [2:0] dt1, dt2;
        logic       en;
        logic [7:0] duty;
        logic [3:0] ef;
        logic [2:0] ed1, ed2, est;
        logic       efl;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic s, sp, f, c, p, input logic [3:0] fq,
                                input logic [2:0] a, b, input logic en, input logic [7:0] d,
                                input logic [3:0] ef, input logic [2:0] ea, eb, es, input logic efl);
        vec_t v;
        v.start = s; v.stop = sp; v.fault = f; v.clr = c; v.pe = p;
        v.freq = fq; v.dt1 = a; v.dt2 = b;
        v.en = en; v.duty = d; v.ef = ef; v.ed1 = ea; v.ed2 = eb; v.est = es; v.efl = efl;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        pe = 1'b1;
        tick();
        pe = 1'b0;
        tick();
    endtask

    task automatic chk_m(input string nm, input int en, input int duty, input int st);
        chk({nm, ".EN"}, en_m, en);
        chk({nm, ".duty"}, duty_m, duty);
        chk({nm, ".state"}, st_m, st);
    endtask

    initial begin
        //           st sp f  c  p  freq   dt1   dt2  | EN duty freq  dt1   dt2   st fl
        tbl[0]  = mk(1, 1, 0, 0, 0, 4'd15, 3'd0, 3'd7, 0, 8'd0, 4'd6,  3'd5, 3'd5, 3'd0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0, 4'd15, 3'd0, 3'd7, 0, 8'd0, 4'd6,  3'd5, 3'd5, 3'd5, 1);
        tbl[2]  = mk(0, 0, 1, 1, 0, 4'd15, 3'd0, 3'd7, 0, 8'd0, 4'd6,  3'd5, 3'd5, 3'd5, 1);
        tbl[3]  = mk(0, 0, 0, 1, 0, 4'd15, 3'd0, 3'd7, 0, 8'd0, 4'd6,  3'd5, 3'd5, 3'd0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 4'd15, 3'd0, 3'd7, 0, 8'd0, 4'd10, 3'd5, 3'd5, 3'd1, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 4'd15, 3'd0, 3'd7, 0, 8'd0, 4'd10, 3'd5, 3'd5, 3'd4, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 4'd15, 3'd0, 3'd7, 0, 8'd0, 4'd10, 3'd5, 3'd5, 3'd0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 4'd9,  3'd3, 3'd1, 0, 8'd0, 4'd9,  3'd3, 3'd1, 3'd1, 0);
        tbl[8]  = mk(1, 0, 1, 0, 0, 4'd9,  3'd3, 3'd1, 0, 8'd0, 4'd9,  3'd3, 3'd1, 3'd5, 1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 4'd9,  3'd3, 3'd1, 0, 8'd0, 4'd9,  3'd3, 3'd1, 3'd0, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 4'd10, 3'd5, 3'd6, 0, 8'd0, 4'd10, 3'd5, 3'd5, 3'd1, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 4'd0,  3'd5, 3'd6, 0, 8'd0, 4'd10, 3'd5, 3'd5, 3'd1, 0);

        // Reset values
        #22;
        chk_m("rst", 0, 0, 0);
        chk("rst.freq", freq_m, 6);
        chk("rst.dt1", dt1_m, 5);
        chk("rst.dt2", dt2_m, 5);
        chk("rst.fl", fl_m, 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; fault = tbl[i].fault;
            clear_fault = tbl[i].clr; pe = tbl[i].pe;
            freq_req = tbl[i].freq; dt1_req = tbl[i].dt1; dt2_req = tbl[i].dt2;
            tick();
            chk($sformatf("tbl%0d.EN", i), en_m, tbl[i].en);
            chk($sformatf("tbl%0d.duty", i), duty_m, tbl[i].duty);
            chk($sformatf("tbl%0d.freq", i), freq_m, tbl[i].ef);
            chk($sformatf("tbl%0d.dt1", i), dt1_m, tbl[i].ed1);
            chk($sformatf("tbl%0d.dt2", i), dt2_m, tbl[i].ed2);
            chk($sformatf("tbl%0d.state", i), st_m, tbl[i].est);
            chk($sformatf("tbl%0d.fl", i), fl_m, tbl[i].efl);
        end
        start = 0; stop = 0; fault = 0; clear_fault = 0; pe = 0;

        // Asynchronous reset in PRECHG, checked before any clock edge
        #2 resetn = 1'b0;
        #1;
        chk_m("arst", 0, 0, 0);
        chk("arst.freq", freq_m, 6);
        chk("arst.dt1", dt1_m, 5);
        #1 resetn = 1'b1;
        tick();
        chk("arst.idle_wo_start", st_m, 0);

        // Precharge: exactly 10 clocks, then next period_end
        duty_tgt = 8'd150; freq_req = 4'd3; dt1_req = 3'd2; dt2_req = 3'd4; start = 1'b1;
        tick();
        chk("pre.state", st_m, 1);
        chk("pre.freq", freq_m, 3);
        chk("pre.dt1", dt1_m, 2);
        chk("pre.dt2", dt2_m, 4);
        repeat (8) tick();
        pe = 1'b1;
        tick();
        chk_m("pre.early_pe", 0, 0, 1);
        tick();
        chk_m("pre.to_ramp", 1, 0, 2);
        pe = 1'b0;
        tick();

        // Soft start to 150
        for (int k = 1; k <= 150; k++) begin
            pulse();
            if (k == 1)   chk_m("ramp.k1", 1, 1, 2);
            if (k == 149) chk_m("ramp.k149", 1, 149, 2);
            if (k == 150) chk_m("ramp.k150", 1, 150, 3);
        end

        // Slew down to 100 in RUN
        duty_tgt = 8'd100;
        for (int k = 1; k <= 51; k++) begin
            pulse();
            if (k == 1)  chk_m("slew.k1", 1, 149, 3);
            if (k == 50) chk_m("slew.k50", 1, 100, 3);
            if (k == 51) chk("slew.hold", duty_m, 100);
        end
        chk("slew.freq", freq_m, 3);

        // Frequency change only on period_end, restarts ramp
        freq_req = 4'd15; dt1_req = 3'd7;
        tick();
        chk("fchg.wait.freq", freq_m, 3);
        chk("fchg.wait.dt1", dt1_m, 2);
        chk("fchg.wait.duty", duty_m, 100);
        pe = 1'b1;
        tick();
        chk("fchg.freq", freq_m, 10);
        chk("fchg.dt1", dt1_m, 5);
        chk_m("fchg", 1, 0, 2);
        pe = 1'b0;
        tick();

        // Fault during ramp at duty 40
        duty_tgt = 8'd200;
        repeat (40) pulse();
        chk_m("ramp40", 1, 40, 2);
        fault = 1'b1;
        tick();
        chk_m("flt", 0, 0, 5);
        chk("flt.fl", fl_m, 1);
        clear_fault = 1'b1;
        tick();
        chk("flt.clr_hi", st_m, 5);
        clear_fault = 1'b0; fault = 1'b0;
`ifdef DPWM_SEQ_AUTORETRY_EN
        repeat (19) tick();
        chk("retry.19", st_m, 5);
        tick();
        chk("retry.20", st_m, 1);
        chk("retry.freq", freq_m, 10);
        chk("retry.fl", fl_m, 0);
        fault = 1'b1;
        tick();
        chk("retry.refault", st_m, 5);
        fault = 1'b0;
`else
        repeat (40) tick();
        chk("flt.hold", st_m, 5);
        chk("flt.hold.EN", en_m, 0);
`endif
        clear_fault = 1'b1; start = 1'b0;
        tick();
        clear_fault = 1'b0;
        chk("flt.clr", st_m, 0);
        chk("flt.clr.fl", fl_m, 0);

        // Shutdown from RUN at duty 3, stop outranks start
        duty_tgt = 8'd3; start = 1'b1;
        tick();
        chk("sd.pre", st_m, 1);
        repeat (9) tick();
        pe = 1'b1;
        tick();
        pe = 1'b0;
        chk_m("sd.ramp", 1, 0, 2);
        tick();
        repeat (3) pulse();
        chk_m("sd.run3", 1, 3, 3);
        stop = 1'b1;
        tick();
        chk_m("sd.enter", 1, 3, 4);
        pulse();
        chk_m("sd.d2", 1, 2, 4);
        pulse();
        chk_m("sd.d1", 1, 1, 4);
        pe = 1'b1;
        tick();
        pe = 1'b0;
        chk_m("sd.d0", 1, 0, 4);
        tick();
        chk_m("sd.idle", 0, 0, 0);
        tick();
        chk("sd.stop_holds_idle", st_m, 0);
        stop = 1'b0; start = 1'b0;

        // Divider instance: RAMP_DIV=3, PRECHARGE_CYC=2, DUTY_MAX=20
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
        duty_tgt = 8'd200; freq_req = 4'd4; dt1_req = 3'd1; dt2_req = 3'd1; start = 1'b1;
        tick();
        chk("div.pre", st_d, 1);
        tick();
        pe = 1'b1;
        tick();
        pe = 1'b0;
        chk("div.ramp", st_d, 2);
        chk("div.EN", en_d, 1);
        tick();
        for (int k = 1; k <= 60; k++) begin
            pulse();
            if (k == 2)  chk("div.k2", duty_d, 0);
            if (k == 3)  chk("div.k3", duty_d, 1);
            if (k == 59) chk("div.k59", duty_d, 19);
            if (k == 59) chk("div.k59.st", st_d, 2);
            if (k == 60) chk("div.k60", duty_d, 20);
            if (k == 60) chk("div.k60.st", st_d, 3);
        end
        repeat (3) pulse();
        chk("div.clamp", duty_d, 20);
        duty_tgt = 8'd18;
        for (int k = 1; k <= 6; k++) begin
            pulse();
            if (k == 2) chk("div.dn2", duty_d, 20);
            if (k == 3) chk("div.dn3", duty_d, 19);
            if (k == 6) chk("div.dn6", duty_d, 18);
        end
        freq_req = 4'd5;
        pulse();
        chk("div.fchg.freq", freq_d, 5);
        chk("div.fchg.duty", duty_d, 0);
        chk("div.fchg.st", st_d, 2);
        repeat (6) pulse();
        chk("div.rr2", duty_d, 2);
        duty_tgt = 8'd1;
        pulse();
        chk("div.jump.duty", duty_d, 1);
        chk("div.jump.st", st_d, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
